oc8051_sfr_arb: RTL and testbench
=================================

Name: oc8051_sfr_arb

Overview:
- Arbiter and sequencer that shares the SFR block's access port between the CPU core and a debug/host requester.
- Muxes the address, write-data and write-enable lines into the SFR register file.
- Stalls the core while a debug transaction owns the port.
- Sequences the registered one-cycle SFR read, including the SFR wait_data stretch, and returns read data with a four-phase req/ack handshake.
- Sits between the decode/execute stage, the debug interface and the SFR register file.

Parameters:
- STARVE_MAX, 8: cycles a pending debug request may be blocked by core traffic before the arbiter forces a debug grant; legal range 1..255.
- TIMEOUT, 15: cycles the arbiter waits on sfr_wait before aborting the debug access with an error; legal range 1..255.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- core_req  in  1  core requests SFR port this cycle.
- core_we  in  1  core write enable.
- core_adr  in  8  core SFR address.
- core_dat  in  8  core write data.
- core_stall  out  1  core must hold its instruction and request.
- dbg_req  in  1  debug request; four-phase handshake.
- dbg_we  in  1  debug write (1) / read (0).
- dbg_adr  in  8  debug SFR address.
- dbg_wdat  in  8  debug write data.
- dbg_ack  out  1  single-cycle completion pulse.
- dbg_rdat  out  8  read data; valid with dbg_ack, held until the next ack.
- dbg_err  out  1  error flag; valid with dbg_ack.
- sfr_adr  out  8  address to the SFR block (drives both read and write address).
- sfr_dat  out  8  write data to the SFR block.
- sfr_we  out  1  write enable to the SFR block.
- sfr_rdat  in  8  registered SFR read data (dat0).
- sfr_wait  in  1  SFR wait_data; read data not yet valid.

Behaviour:
- Reset values: all outputs 0, state IDLE, starvation counter 0, timeout counter 0, armed flag 1.
- States: IDLE, GRANT, RDWAIT, ACK, DRAIN. State is encoded in a register; core_stall, dbg_ack and sfr_* selection decode only from registered state, so there is no combinational path from dbg_* to core_stall.
- IDLE:
  - Core owns the port: sfr_adr=core_adr, sfr_dat=core_dat, sfr_we=core_we & core_req.
  - Starvation counter increments, saturating, while dbg_req & armed & core_req; it clears otherwise.
  - Go to GRANT when dbg_req & armed & (!core_req | starve_cnt==STARVE_MAX).
- GRANT (exactly 1 cycle):
  - core_stall=1; sfr_adr=dbg_adr, sfr_dat=dbg_wdat, sfr_we=dbg_we; the write commits on this edge.
  - Starvation counter clears. Go to RDWAIT.
- RDWAIT:
  - core_stall=1, sfr_adr=dbg_adr, sfr_we=0.
  - If sfr_wait=0: capture dbg_rdat=sfr_rdat (also for writes, giving read-back), dbg_err=0, go to ACK.
  - If sfr_wait=1: increment the timeout counter.
  - If the timeout counter reaches TIMEOUT: dbg_rdat=8'h00, dbg_err=1, go to ACK.
- ACK (1 cycle): dbg_ack=1, core_stall=0, core owns the port, armed cleared. Go to DRAIN.
- DRAIN: core owns the port; when dbg_req=0, set armed and go to IDLE. A dbg_req held high across ack is never serviced twice.
- Latency:
  - Uncontended debug access: dbg_req sampled high in IDLE, then GRANT, RDWAIT, ACK; dbg_ack is high 3 cycles after the request edge, plus one cycle per cycle of sfr_wait.
  - Worst-case core stall: 2+TIMEOUT cycles.
- Simultaneous events:
  - Core and debug requesting in IDLE with starve_cnt<STARVE_MAX: core wins.
  - starve_cnt==STARVE_MAX: debug wins the same cycle.
- Mid-transaction changes: dbg_adr, dbg_we and dbg_wdat must stay stable from request until ack. Changes after GRANT do not affect the captured write, but the read address follows dbg_adr.
- Reset mid-operation: return immediately to IDLE with all outputs 0. An in-flight debug write may or may not have committed; no ack is issued.

Optional Feature:
- Macro OC8051_SFR_ARB_PROT_EN.
- With the macro defined: debug writes to SP (8'h81) and PSW (8'hD0) are blocked. GRANT drives sfr_we=0, the transaction completes normally through RDWAIT, and ACK reports dbg_err=1 with dbg_rdat holding the current register value.
- Without the macro: all debug writes are allowed, and dbg_err is set only on timeout.

Decomposition:
- oc8051_defines.v holds:
  - the state encodings OC8051_ARB_IDLE, OC8051_ARB_GRANT, OC8051_ARB_RDWAIT, OC8051_ARB_ACK and OC8051_ARB_DRAIN (3-bit);
  - the protected addresses, reusing the existing SFR address constants for SP and PSW.
- One sub-module: oc8051_sat_cnt, an 8-bit saturating counter with clear, increment and a compare-to-limit output. It is instantiated twice, once for the starvation count and once for the timeout count.

Test Plan:
1. Idle core, debug read of 8'hE0 with sfr_rdat=8'h5A and sfr_wait=0: dbg_ack 3 cycles after the request, dbg_rdat=8'h5A, dbg_err=0, core_stall high for exactly 2 cycles.
2. core_req held high, dbg_req asserted, STARVE_MAX=8: GRANT entered on the 9th cycle; core_stall for 2 cycles; core drives sfr_* again in the ACK cycle.
3. Debug write 8'h33 to 8'hF0: sfr_we=1, sfr_adr=8'hF0, sfr_dat=8'h33 for exactly one cycle; no second write while dbg_req is held high for 5 cycles after ack.
4. sfr_wait stuck at 1, TIMEOUT=15: ack after 17 cycles of core_stall total, dbg_err=1, dbg_rdat=8'h00; the next access succeeds normally.
5. rst_n pulsed low during RDWAIT: core_stall, dbg_ack and sfr_we go to 0 asynchronously; the arbiter restarts from IDLE and serves a new request.
6. Macro defined, debug write 8'h07 to 8'h81: sfr_we stays 0, dbg_err=1, dbg_rdat equals the SP value; a write to 8'hE0 is unaffected.

Source files
------------

// File: rtl/oc8051_sfr_arb_pkg.sv
// Shared types and constants for the SFR port arbiter: state encodings,
// protected SFR addresses and the SFR access bus payload.
package oc8051_sfr_arb_pkg;

  localparam int unsigned SFR_AW = 8;
  localparam int unsigned SFR_DW = 8;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [2:0] {
    OC8051_ARB_IDLE   = 3'd0,
    OC8051_ARB_GRANT  = 3'd1,
    OC8051_ARB_RDWAIT = 3'd2,
    OC8051_ARB_ACK    = 3'd3,
    OC8051_ARB_DRAIN  = 3'd4
  } arb_state_t;

  // Existing SFR map addresses that debug writes may not touch when protected
  localparam logic [SFR_AW-1:0] OC8051_SFR_SP  = 8'h81;
  localparam logic [SFR_AW-1:0] OC8051_SFR_PSW = 8'hD0;

  typedef struct packed {
    logic [SFR_AW-1:0] adr;
    logic [SFR_DW-1:0] dat;
    logic              we;
  } sfr_bus_t;

  function automatic logic is_prot_adr(input logic [SFR_AW-1:0] adr);
    return (adr == OC8051_SFR_SP) || (adr == OC8051_SFR_PSW);
  endfunction

endpackage

// File: rtl/oc8051_sat_cnt.sv
// Saturating up-counter with synchronous clear; hit_c flags count == limit
// and the count holds there until cleared.
module oc8051_sat_cnt
  import oc8051_sfr_arb_pkg::*;
#(
  parameter int unsigned W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic         hit_c
);

  logic [W-1:0] cnt;

  assign hit_c = (cnt == limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !hit_c) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/oc8051_sfr_arb.sv
// Shares the SFR access port between the CPU core and a debug requester.
// Define OC8051_SFR_ARB_PROT_EN to block debug writes to SP and PSW.
module oc8051_sfr_arb
  import oc8051_sfr_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 8,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [SFR_AW-1:0] core_adr,
  input  logic [SFR_DW-1:0] core_dat,
  output logic              core_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [SFR_AW-1:0] dbg_adr,
  input  logic [SFR_DW-1:0] dbg_wdat,
  output logic              dbg_ack,
  output logic [SFR_DW-1:0] dbg_rdat,
  output logic              dbg_err,
  output logic [SFR_AW-1:0] sfr_adr,
  output logic [SFR_DW-1:0] sfr_dat,
  output logic              sfr_we,
  input  logic [SFR_DW-1:0] sfr_rdat,
  input  logic              sfr_wait
);

  arb_state_t state;
  logic       armed;
  logic       blk;

  logic       starve_inc_c;
  logic       starve_clr_c;
  logic       starve_hit_c;
  logic       to_inc_c;
  logic       to_clr_c;
  logic       to_hit_c;
  logic       grant_go_c;
  logic       prot_c;
  sfr_bus_t   sfr_bus_c;

  // Starvation count runs only while core traffic is blocking an armed debug request
  assign starve_inc_c = (state == OC8051_ARB_IDLE) && dbg_req && armed && core_req;
  assign starve_clr_c = !starve_inc_c;
  assign grant_go_c   = (state == OC8051_ARB_IDLE) && dbg_req && armed &&
                        (!core_req || starve_hit_c);

  assign to_inc_c = (state == OC8051_ARB_RDWAIT) && sfr_wait;
  assign to_clr_c = (state != OC8051_ARB_RDWAIT);

`ifdef OC8051_SFR_ARB_PROT_EN
  assign prot_c = dbg_we && is_prot_adr(dbg_adr);
`else
  assign prot_c = 1'b0;
`endif

  oc8051_sat_cnt #(.W(CNT_W)) u_starve_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (starve_clr_c),
    .inc   (starve_inc_c),
    .limit (CNT_W'(STARVE_MAX)),
    .hit_c (starve_hit_c)
  );

  oc8051_sat_cnt #(.W(CNT_W)) u_to_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (to_clr_c),
    .inc   (to_inc_c),
    .limit (CNT_W'(TIMEOUT)),
    .hit_c (to_hit_c)
  );

  // Port ownership decodes from registered state only
  always_comb begin
    sfr_bus_c.adr = core_adr;
    sfr_bus_c.dat = core_dat;
    sfr_bus_c.we  = core_we & core_req;
    case (state)
      OC8051_ARB_GRANT: begin
        sfr_bus_c.adr = dbg_adr;
        sfr_bus_c.dat = dbg_wdat;
        sfr_bus_c.we  = dbg_we & !prot_c;
      end
      OC8051_ARB_RDWAIT: begin
        sfr_bus_c.adr = dbg_adr;
        sfr_bus_c.dat = dbg_wdat;
        sfr_bus_c.we  = 1'b0;
      end
      default: ;
    endcase
  end

  assign sfr_adr = sfr_bus_c.adr;
  assign sfr_dat = sfr_bus_c.dat;
  assign sfr_we  = sfr_bus_c.we;

  // Sequencer; stall and ack are registered alongside the state transition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= OC8051_ARB_IDLE;
      core_stall <= 1'b0;
      dbg_ack    <= 1'b0;
      dbg_rdat   <= '0;
      dbg_err    <= 1'b0;
      armed      <= 1'b1;
      blk        <= 1'b0;
    end else begin
      dbg_ack <= 1'b0;
      case (state)
        OC8051_ARB_IDLE: begin
          if (grant_go_c) begin
            state      <= OC8051_ARB_GRANT;
            core_stall <= 1'b1;
          end
        end
        OC8051_ARB_GRANT: begin
          state <= OC8051_ARB_RDWAIT;
          blk   <= prot_c;
        end
        OC8051_ARB_RDWAIT: begin
          if (!sfr_wait) begin
            dbg_rdat   <= sfr_rdat;
            dbg_err    <= blk;
            dbg_ack    <= 1'b1;
            core_stall <= 1'b0;
            state      <= OC8051_ARB_ACK;
          end else if (to_hit_c) begin
            dbg_rdat   <= '0;
            dbg_err    <= 1'b1;
            dbg_ack    <= 1'b1;
            core_stall <= 1'b0;
            state      <= OC8051_ARB_ACK;
          end
        end
        OC8051_ARB_ACK: begin
          armed <= 1'b0;
          state <= OC8051_ARB_DRAIN;
        end
        OC8051_ARB_DRAIN: begin
          // A request still held from the last ack must drop before re-arming
          if (!dbg_req) begin
            armed <= 1'b1;
            state <= OC8051_ARB_IDLE;
          end
        end
        default: begin
          state      <= OC8051_ARB_IDLE;
          core_stall <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oc8051_sfr_arb.sv
// Scoreboard bench for oc8051_sfr_arb: expected debug responses are queued
// at issue time and checked by a monitor whenever dbg_ack is presented.
module tb_oc8051_sfr_arb;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       core_req = 1'b0;
  logic       core_we  = 1'b0;
  logic [7:0] core_adr = 8'h00;
  logic [7:0] core_dat = 8'h00;
  logic       dbg_req  = 1'b0;
  logic       dbg_we   = 1'b0;
  logic [7:0] dbg_adr  = 8'h00;
  logic [7:0] dbg_wdat = 8'h00;
  logic [7:0] sfr_rdat = 8'h00;
  logic       sfr_wait = 1'b0;
  logic       core_stall, dbg_ack, dbg_err, sfr_we;
  logic [7:0] dbg_rdat, sfr_adr, sfr_dat;

  oc8051_sfr_arb #(.STARVE_MAX(8), .TIMEOUT(15)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_adr   (core_adr),
    .core_dat   (core_dat),
    .core_stall (core_stall),
    .dbg_req    (dbg_req),
    .dbg_we     (dbg_we),
    .dbg_adr    (dbg_adr),
    .dbg_wdat   (dbg_wdat),
    .dbg_ack    (dbg_ack),
    .dbg_rdat   (dbg_rdat),
    .dbg_err    (dbg_err),
    .sfr_adr    (sfr_adr),
    .sfr_dat    (sfr_dat),
    .sfr_we     (sfr_we),
    .sfr_rdat   (sfr_rdat),
    .sfr_wait   (sfr_wait)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] rdat;
    logic       err;
  } exp_t;

  exp_t       sbq[$];
  exp_t       mon_e;
  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  int         ack_cnt = 0;
  int         ack_cyc = 0;
  int         stall_cnt = 0;
  int         we_cnt = 0;
  logic [7:0] ack_sfr_adr = 8'h00;
  logic [7:0] we_adr = 8'h00;
  logic [7:0] we_dat = 8'h00;
  int         lat;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: tallies stall/write cycles and scores every ack against the queue
  always @(negedge clk) begin
    if (rst_n) begin
      if (core_stall) stall_cnt++;
      if (sfr_we) begin
        we_cnt++;
        we_adr = sfr_adr;
        we_dat = sfr_dat;
      end
      if (dbg_ack) begin
        ack_cnt++;
        ack_cyc = cyc;
        ack_sfr_adr = sfr_adr;
        check("sb_pending", int'(sbq.size() != 0), 1);
        if (sbq.size() != 0) begin
          mon_e = sbq.pop_front();
          check("ack_rdat", int'(dbg_rdat), int'(mon_e.rdat));
          check("ack_err", int'(dbg_err), int'(mon_e.err));
        end
      end
    end
  end

  // Issues one debug access, holds dbg_req 'hold' extra cycles after ack
  task automatic dbg_xact(input logic we, input logic [7:0] adr, input logic [7:0] wdat,
                          input logic [7:0] er, input logic ee, input int hold,
                          output int l);
    exp_t e;
    int   a0;
    int   r0;
    bit   seen;
    e.rdat = er;
    e.err  = ee;
    sbq.push_back(e);
    a0 = ack_cnt;
    r0 = cyc;
    dbg_we   = we;
    dbg_adr  = adr;
    dbg_wdat = wdat;
    dbg_req  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk);
      if (ack_cnt != a0) seen = 1'b1;
    end
    check("ack_seen", int'(seen), 1);
    l = seen ? (ack_cyc - r0) : -1;
    #1;
    repeat (hold) @(posedge clk);
    #1;
    dbg_req = 1'b0;
    dbg_we  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("ack_once", ack_cnt - a0, 1);
    if (!seen) sbq.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #2;
    check("rst_stall", int'(core_stall), 0);
    check("rst_ack", int'(dbg_ack), 0);
    check("rst_rdat", int'(dbg_rdat), 0);
    check("rst_err", int'(dbg_err), 0);
    check("rst_we", int'(sfr_we), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 1: uncontended read
    sfr_rdat = 8'h5A;
    stall_cnt = 0;
    dbg_xact(1'b0, 8'hE0, 8'h00, 8'h5A, 1'b0, 0, lat);
    check("t1_latency", lat, 3);
    check("t1_stall", stall_cnt, 2);

    // 2: core holds the port, debug forced in by starvation
    core_req = 1'b1;
    core_we  = 1'b0;
    core_adr = 8'hA5;
    sfr_rdat = 8'h3C;
    @(posedge clk);
    #1;
    stall_cnt = 0;
    dbg_xact(1'b0, 8'hE0, 8'h00, 8'h3C, 1'b0, 0, lat);
    check("t2_latency", lat, 11);
    check("t2_stall", stall_cnt, 2);
    check("t2_ack_core_adr", int'(ack_sfr_adr), 8'hA5);
    core_req = 1'b0;
    core_adr = 8'h00;

    // 3: single write, request held after ack
    sfr_rdat = 8'h33;
    we_cnt = 0;
    dbg_xact(1'b1, 8'hF0, 8'h33, 8'h33, 1'b0, 5, lat);
    check("t3_we_count", we_cnt, 1);
    check("t3_we_adr", int'(we_adr), 8'hF0);
    check("t3_we_dat", int'(we_dat), 8'h33);

    // 4: stuck sfr_wait times out, then a clean access
    sfr_wait = 1'b1;
    sfr_rdat = 8'h77;
    stall_cnt = 0;
    dbg_xact(1'b0, 8'hE0, 8'h00, 8'h00, 1'b1, 0, lat);
    check("t4_stall", stall_cnt, 17);
    check("t4_latency", lat, 18);
    sfr_wait = 1'b0;
    sfr_rdat = 8'h5A;
    dbg_xact(1'b0, 8'hE0, 8'h00, 8'h5A, 1'b0, 0, lat);
    check("t4_recover_latency", lat, 3);

    // 5: reset while in RDWAIT
    sfr_wait = 1'b1;
    dbg_adr  = 8'hE0;
    dbg_we   = 1'b0;
    dbg_req  = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("t5_stall_before", int'(core_stall), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_stall", int'(core_stall), 0);
    check("t5_rst_ack", int'(dbg_ack), 0);
    check("t5_rst_we", int'(sfr_we), 0);
    check("t5_rst_rdat", int'(dbg_rdat), 0);
    dbg_req  = 1'b0;
    sfr_wait = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    sfr_rdat = 8'hC3;
    stall_cnt = 0;
    dbg_xact(1'b0, 8'hF0, 8'h00, 8'hC3, 1'b0, 0, lat);
    check("t5_restart_latency", lat, 3);
    check("t5_restart_stall", stall_cnt, 2);

    // 6: debug write to SP, then to an unprotected register
    sfr_rdat = 8'h42;
    we_cnt = 0;
`ifdef OC8051_SFR_ARB_PROT_EN
    dbg_xact(1'b1, 8'h81, 8'h07, 8'h42, 1'b1, 0, lat);
    check("t6_sp_we_count", we_cnt, 0);
`else
    dbg_xact(1'b1, 8'h81, 8'h07, 8'h42, 1'b0, 0, lat);
    check("t6_sp_we_count", we_cnt, 1);
`endif
    sfr_rdat = 8'h11;
    we_cnt = 0;
    dbg_xact(1'b1, 8'hE0, 8'h11, 8'h11, 1'b0, 0, lat);
    check("t6_acc_we_count", we_cnt, 1);
    check("t6_acc_we_adr", int'(we_adr), 8'hE0);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
